mac_rx_deframer: RTL

//  Receive-side MAC deframer: takes byte-wide MII/PHY receive data and validates each Ethernet frame.

---
 rtl/mac_rx_deframer_if.sv | 28 ++
 rtl/mac_rx_deframer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_deframer_if.sv
// Receive-side MII byte stream in, deframed payload and per-frame status out.
interface mac_rx_deframer_if;
    logic        rxdv;
    logic [7:0]  rxd;
    logic        rxer;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_sof;
    logic        rx_done;
    logic        rx_good;
    logic [4:0]  rx_err;
    logic [10:0] rx_len;
    logic [47:0] rx_dst;
    logic [47:0] rx_src;
    logic [15:0] rx_type;

    modport slave (
        input  rxdv, rxd, rxer,
        output rx_valid, rx_data, rx_sof, rx_done, rx_good, rx_err, rx_len,
               rx_dst, rx_src, rx_type
    );

    modport master (
        output rxdv, rxd, rxer,
        input  rx_valid, rx_data, rx_sof, rx_done, rx_good, rx_err, rx_len,
               rx_dst, rx_src, rx_type
    );
endinterface

// File: rtl/mac_rx_deframer.sv
// Ethernet receive deframer: strips preamble/SFD/FCS, filters on destination,
// checks CRC-32 and streams payload with a one-cycle end-of-frame status strobe.
module mac_rx_deframer #(
    parameter logic [47:0] MAC_ADDR  = 48'h020000000001,
    parameter bit          PROMISC   = 1'b0,
    parameter int          PRE_MIN   = 1,
    parameter int          MAX_FRAME = 1518
) (
    input  logic              in_rxc,
    input  logic              in_rst,
    mac_rx_deframer_if.slave  rx
);

    localparam logic [7:0]  PRE_MIN_C   = 8'(PRE_MIN);
    localparam logic [10:0] MAX_K       = 11'(MAX_FRAME);
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_FRAME, S_DROP, S_DROP_END} state_t;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [10:0] sat_len(input logic [10:0] total);
        return (total >= 11'd18) ? (total - 11'd18) : 11'd0;
    endfunction

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : (v + 11'd1);
    endfunction

    state_t      state, state_nxt;
    logic        armed;
    logic [7:0]  precnt;
    logic [10:0] k;
    logic [31:0] crc;
    logic [7:0]  dly [4];
    logic [47:0] dst, src;
    logic [15:0] etype;
    logic        addr_miss, giant, rxer_f, first_pl;

    logic        start_pre, pre_inc, start_frame, frame_byte, frame_end, giant_hit, emit;
    logic [47:0] dst_full;
    logic        miss_now;
    logic [4:0]  err_now;

    logic        vld_p1, sof_p1, done_p1, good_p1;
    logic [7:0]  data_p1;
    logic [4:0]  err_p1;
    logic [10:0] len_p1;

    assign dst_full = {dst[39:0], rx.rxd};
    assign miss_now = !PROMISC && (dst_full != MAC_ADDR) && (dst_full != 48'hFFFF_FFFF_FFFF);
    assign err_now  = {addr_miss, giant, (k < 11'd64), rxer_f, (crc != CRC_RESIDUE)};
    assign emit     = frame_byte && !giant_hit && !addr_miss && (k >= 11'd18);

    always_ff @(posedge in_rxc) begin
        if (in_rst) begin
            state <= S_IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!rx.rxdv) armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_pre   = 1'b0;
        pre_inc     = 1'b0;
        start_frame = 1'b0;
        frame_byte  = 1'b0;
        frame_end   = 1'b0;
        giant_hit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && rx.rxdv && rx.rxd == 8'h55) begin
                    state_nxt = S_PRE;
                    start_pre = 1'b1;
                end
            end
            S_PRE: begin
                if (!rx.rxdv) begin
                    state_nxt = S_IDLE;
                end else if (rx.rxd == 8'h55) begin
                    pre_inc = 1'b1;
                end else if (rx.rxd == 8'hD5 && precnt >= PRE_MIN_C) begin
                    state_nxt   = S_FRAME;
                    start_frame = 1'b1;
                end else begin
                    state_nxt = S_DROP;
                end
            end
            S_FRAME: begin
                if (!rx.rxdv) begin
                    state_nxt = S_IDLE;
                    frame_end = 1'b1;
                end else begin
                    frame_byte = 1'b1;
                    if (k == MAX_K) begin
                        giant_hit = 1'b1;
                        state_nxt = S_DROP_END;
                    end
                end
            end
            S_DROP: begin
                if (!rx.rxdv) state_nxt = S_IDLE;
            end
            S_DROP_END: begin
                if (!rx.rxdv) begin
                    state_nxt = S_IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0: byte counter, header capture and frame flags
    always_ff @(posedge in_rxc) begin
        if (in_rst) begin
            precnt    <= 8'd0;
            k         <= 11'd0;
            addr_miss <= 1'b0;
            giant     <= 1'b0;
            rxer_f    <= 1'b0;
            first_pl  <= 1'b0;
            dst       <= 48'd0;
            src       <= 48'd0;
            etype     <= 16'd0;
        end else begin
            if (start_pre)
                precnt <= 8'd1;
            else if (pre_inc && precnt != 8'hFF)
                precnt <= precnt + 8'd1;
            if (start_frame) begin
                k         <= 11'd0;
                addr_miss <= 1'b0;
                giant     <= 1'b0;
                rxer_f    <= 1'b0;
                first_pl  <= 1'b1;
            end
            if (frame_byte) begin
                k <= sat_inc(k);
                if (k < 11'd6)
                    dst <= dst_full;
                else if (k < 11'd12)
                    src <= {src[39:0], rx.rxd};
                else if (k < 11'd14)
                    etype <= {etype[7:0], rx.rxd};
                if (k == 11'd5) addr_miss <= miss_now;
                if (rx.rxer) rxer_f <= 1'b1;
                if (giant_hit) giant <= 1'b1;
                if (emit) first_pl <= 1'b0;
            end
        end
    end

    // The four newest bytes are held back so the trailing FCS is never emitted.
    always_ff @(posedge in_rxc) begin
        if (start_frame)
            crc <= 32'hFFFF_FFFF;
        else if (frame_byte)
            crc <= crc_byte(crc, rx.rxd);
        if (frame_byte) begin
            dly[0] <= rx.rxd;
            dly[1] <= dly[0];
            dly[2] <= dly[1];
            dly[3] <= dly[2];
        end
    end

    // Stage p1: registered payload strobe and end-of-frame status
    always_ff @(posedge in_rxc) begin
        if (in_rst) begin
            vld_p1  <= 1'b0;
            sof_p1  <= 1'b0;
            data_p1 <= 8'd0;
            done_p1 <= 1'b0;
            good_p1 <= 1'b0;
            err_p1  <= 5'd0;
            len_p1  <= 11'd0;
        end else begin
            vld_p1  <= emit;
            sof_p1  <= emit && first_pl;
            done_p1 <= frame_end;
            good_p1 <= frame_end && (err_now == 5'd0);
            if (emit) data_p1 <= dly[3];
            if (frame_end) begin
                err_p1 <= err_now;
                len_p1 <= sat_len(k);
            end
        end
    end

    assign rx.rx_valid = vld_p1;
    assign rx.rx_data  = data_p1;
    assign rx.rx_sof   = sof_p1;
    assign rx.rx_done  = done_p1;
    assign rx.rx_good  = good_p1;
    assign rx.rx_err   = err_p1;
    assign rx.rx_len   = len_p1;
    assign rx.rx_dst   = dst;
    assign rx.rx_src   = src;
    assign rx.rx_type  = etype;

endmodule
